// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: default width, opcodes and FSM state encoding.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/div_iter_core.sv
// Restoring unsigned divider: one quotient bit per step, quotient shifts in through the dividend register.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // The extra top bit of diff is the borrow: set means the trial subtract failed.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (sign-magnitude datapath, sign fixed up at the end).
// Optional build macro MDU_FAST_MUL_EN: single-cycle registered multiply instead of shift-add.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic [1:0]      state_o
);

  // Handshake: a request is taken on a rising edge with start_i=1, busy_o=0, flush_i=0;
  // done_o pulses for exactly one cycle once HI/LO hold the committed result.

  localparam int            CW   = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  logic [1:0]        state_q;
  logic [CW-1:0]     cnt_q;
  logic              is_mul_q, neg_lo_q, neg_hi_q, fix_q, done_q;
  logic [XLEN-1:0]   hi_q, lo_q, res_hi_q, res_lo_q, mcand_q;
  logic [2*XLEN-1:0] acc_q;

  logic              is_mul, is_div, sgn, a_neg, b_neg, b_zero, accept;
  logic [XLEN-1:0]   abs_a, abs_b, quo, rem;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] fast_prod, prod_fix;

  assign busy_o = (state_q != ST_IDLE);

  always_comb begin
    is_mul   = (op_i == OP_MULT) || (op_i == OP_MULTU);
    is_div   = (op_i == OP_DIV) || (op_i == OP_DIVU);
    sgn      = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_neg    = sgn & a_i[XLEN-1];
    b_neg    = sgn & b_i[XLEN-1];
    abs_a    = a_neg ? -a_i : a_i;
    abs_b    = b_neg ? -b_i : b_i;
    b_zero   = (b_i == '0);
    accept   = start_i & ~busy_o & ~flush_i;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    prod_fix = neg_lo_q ? -acc_q : acc_q;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b;
  always_comb begin
    ext_a     = {{XLEN{a_neg}}, a_i};
    ext_b     = {{XLEN{b_neg}}, b_i};
    fast_prod = ext_a * ext_b;
  end
`else
  assign fast_prod = '0;
`endif

  div_iter_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept & is_div & ~b_zero),
    .step      ((state_q == ST_CALC) & ~is_mul_q),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      fix_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            fix_q    <= 1'b0;
            is_mul_q <= is_mul;
            if (is_mul) begin
              mcand_q  <= abs_a;
              acc_q    <= FAST_MUL ? fast_prod : {{XLEN{1'b0}}, abs_b};
              neg_lo_q <= a_neg ^ b_neg;
              state_q  <= ST_CALC;
            end else if (is_div) begin
              if (b_zero) begin
                done_q <= 1'b1;
              end else begin
                neg_lo_q <= a_neg ^ b_neg;
                neg_hi_q <= a_neg;
                state_q  <= ST_CALC;
              end
            end else if (op_i == OP_MTHI) begin
              hi_q   <= a_i;
              done_q <= 1'b1;
            end else if (op_i == OP_MTLO) begin
              lo_q   <= a_i;
              done_q <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (FAST_MUL && is_mul_q) begin
            hi_q    <= acc_q[2*XLEN-1:XLEN];
            lo_q    <= acc_q[XLEN-1:0];
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            if (is_mul_q) acc_q <= {mul_sum, acc_q[XLEN-1:1]};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          // First FIX cycle registers the sign-corrected result, second commits it.
          if (flush_i) begin
            state_q <= ST_IDLE;
            fix_q   <= 1'b0;
          end else if (!fix_q) begin
            fix_q <= 1'b1;
            if (is_mul_q) begin
              res_hi_q <= prod_fix[2*XLEN-1:XLEN];
              res_lo_q <= prod_fix[XLEN-1:0];
            end else begin
              res_lo_q <= neg_lo_q ? -quo : quo;
              res_hi_q <= neg_hi_q ? -rem : rem;
            end
          end else begin
            hi_q    <= res_hi_q;
            lo_q    <= res_lo_q;
            done_q  <= 1'b1;
            fix_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random ops against an arithmetic reference model.
module tb_muldiv_unit;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = 2 * XLEN;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i, b_i;
  logic            flush_i;
  logic            busy_o, done_o;
  logic [XLEN-1:0] hi_o, lo_o;
  logic [1:0]      state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [XLEN-1:0] model_hi, model_lo;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b, input logic [W-1:0] cur);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib;
    logic [W-1:0]    r;
    r = cur;
    case (op)
      OP_MULT: begin
        ia = a; ib = b; sa = ia; sb = ib;
        r = sa * sb;
      end
      OP_MULTU: begin
        ua = a; ub = b;
        r = ua * ub;
      end
      OP_DIV: begin
        ia = a; ib = b;
        if (b == 0) r = cur;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          int q, m;
          q = ia / ib;
          m = ia % ib;
          r = {m, q};
        end
      end
      OP_DIVU: begin
        if (b == 0) r = cur;
        else r = {a % b, a / b};
      end
      OP_MTHI: r = {a, cur[XLEN-1:0]};
      OP_MTLO: r = {cur[W-1:XLEN], a};
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [XLEN-1:0] b);
    if (op == OP_MTHI || op == OP_MTLO) return 0;
    if ((op == OP_DIV || op == OP_DIVU) && b == 0) return 0;
`ifdef MDU_FAST_MUL_EN
    if (op == OP_MULT || op == OP_MULTU) return 1;
`endif
    return XLEN + 2;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done_o pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with no pending request", hi_o, lo_o);
      end else begin
        check("result", {hi_o, lo_o}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [W-1:0] exp, input string name);
    int lat, want;
    want = exp_lat(op, b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 3'($urandom_range(0, 5));
    exp_q.push_back(exp);
    {model_hi, model_lo} = exp;
    if (want > 1) check({name, " busy_after_accept"}, W'(busy_o), W'(1));
    lat = 0;
    while (!done_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, W'(lat), W'(want));
  endtask

  task automatic idle_no_done(input int cycles, input string name);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
    check({name, " no_done"}, W'(seen), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]      op;
    logic [XLEN-1:0] a, b, v;
    logic [W-1:0]    e;

    rst = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {hi_o, lo_o}, '0);
    check("reset_busy_done", W'({busy_o, done_o}), W'(0));
    check("reset_state", W'(state_dbg), W'(ST_IDLE));
    @(negedge clk); rst = 1'b0;

    issue(OP_MULT,  32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, "mult_neg1x2");
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, "multu_max_x2");
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_min_m1");
    e = {model_hi, model_lo};
    issue(OP_DIVU,  32'd100, 32'd0, e, "divu_by_zero");

    // Back-to-back: we are in the done cycle, the next request must be taken right away.
    check("b2b_window", W'({busy_o, done_o}), W'(2'b01));
    v = $urandom;
    issue(OP_MTHI, v, 32'd0, {v, model_lo}, "mthi");
    issue(OP_MTLO, 32'h1234_5678, 32'd0, {model_hi, 32'h1234_5678}, "mtlo");
    issue(OP_DIVU, 32'd1000, 32'd7, {32'd6, 32'd142}, "divu_1000_7");
    check("b2b_window2", W'({busy_o, done_o}), W'(2'b01));
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0}, "mult_min_min");

    // Flush 10 cycles into a DIVU; a start on the same edge must also be ignored.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; a_i = $urandom; b_i = 32'($urandom_range(1, 1000));
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1; start_i = 1'b1; op_i = OP_MTLO; a_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("flush_busy", W'({busy_o, done_o}), W'(0));
    @(negedge clk);
    // Idle edge with flush and start together: flush wins, MTLO must not land.
    @(posedge clk); #1;
    check("flush_prio_lo", {hi_o, lo_o}, {model_hi, model_lo});
    flush_i = 1'b0; start_i = 1'b0;
    idle_no_done(40, "flush");
    check("flush_hilo", {hi_o, lo_o}, {model_hi, model_lo});

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 16));
        default: ;
      endcase
      e = ref_op(op, a, b, {model_hi, model_lo});
      issue(op, a, b, e, "rand");
    end

    // Reset in the middle of a multiply: outputs clear at once, no done afterwards.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MULT; a_i = $urandom; b_i = $urandom;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_hilo", {hi_o, lo_o}, '0);
    check("rst_mid_busy_done", W'({busy_o, done_o}), W'(0));
    model_hi = '0; model_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    idle_no_done(40, "rst_mid");
    issue(OP_MTLO, 32'h1234_5678, 32'd0, {32'h0, 32'h1234_5678}, "mtlo_after_rst");

    repeat (3) @(posedge clk);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand width and the width of HI and LO.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: the request strobe.
REQ-005 The block SHALL have port op_i, input, 3 bits: opcode, one of MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 The block SHALL have ports a_i and b_i, input, XLEN bits each: a_i is the multiplicand or dividend (and the MTHI/MTLO source); b_i is the multiplier or divisor.
REQ-007 The block SHALL have port flush_i, input, 1 bit: aborts the operation in flight.
REQ-008 The block SHALL have port busy_o, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port done_o, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have ports hi_o and lo_o, output, XLEN bits each: the architected HI and LO registers.

Function
REQ-011 A request SHALL be accepted on an edge where start_i=1, busy_o=0 and flush_i=0; start_i at any other time is ignored.
REQ-012 The FSM SHALL have states IDLE, CALC and FIX.
REQ-013 IDLE SHALL go to CALC on acceptance of MULT, MULTU, DIV or DIVU with a nonzero divisor; busy_o=1 in CALC and FIX.
REQ-014 CALC SHALL perform one radix-2 iteration per cycle for XLEN cycles (a shift-add for multiply, a restoring subtract for divide), then go to FIX.
REQ-015 FIX SHALL apply sign correction, commit HI and LO, set done_o=1 for the following cycle, and return to IDLE.
REQ-016 Iterative operation latency SHALL be XLEN+2 edges from the accept edge to the commit edge; busy_o SHALL be low in the done_o cycle, so a back-to-back accept is legal.
REQ-017 MULT and MULTU SHALL produce the 2*XLEN-bit product, signed or unsigned respectively: HI = upper XLEN bits, LO = lower XLEN bits.
REQ-018 DIV SHALL produce LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-019 DIV with the most-negative dividend and a divisor of -1 SHALL give LO = most-negative value and HI = 0.
REQ-020 DIVU SHALL produce LO = unsigned quotient and HI = unsigned remainder.
REQ-021 DIV or DIVU with b_i=0 SHALL leave HI and LO unchanged, skip CALC, and pulse done_o on the cycle after the accept edge.
REQ-022 MTHI SHALL write a_i to HI and MTLO SHALL write a_i to LO on the accept edge, with no busy_o and done_o=1 on the next cycle; the other register is untouched.
REQ-023 flush_i=1 while busy SHALL return the FSM to IDLE on the next edge with no done_o and HI/LO unchanged.
REQ-024 flush_i SHALL take priority over start_i on the same edge.
REQ-025 Operand and counter registers SHALL be captured at accept; later changes on a_i and b_i SHALL NOT affect a result in flight.

Reset
REQ-026 While rst=1 the block SHALL hold state IDLE with hi_o=0, lo_o=0, busy_o=0, done_o=0 and the iteration counter at 0, regardless of clk.
REQ-027 Assertion of rst mid-operation SHALL discard the operation without a done_o pulse.

Configuration
REQ-028 With macro MDU_FAST_MUL_EN defined, MULT and MULTU SHALL compute in one cycle using a registered full-width product: commit on the edge after accept, done_o on the next cycle, FIX bypassed.
REQ-029 With MDU_FAST_MUL_EN undefined, multiplies SHALL use the iterative CALC path of REQ-014; division is iterative in both builds.

Structure
REQ-030 The op_i encodings, the FSM state encoding and the default value of XLEN SHALL live in the shared constants header/package mdu_pkg.
REQ-031 The restoring-division datapath (partial remainder, quotient shift, per-cycle subtract) SHALL be the sub-module div_iter_core, parameterised by XLEN.

Verification
REQ-032 With XLEN=32, the bench SHALL drive MULT a=0xFFFFFFFF, b=2 and check HI=0xFFFFFFFF, LO=0xFFFFFFFE; then MULTU with the same operands and check HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 The bench SHALL drive DIV a=-7, b=2 and check LO=0xFFFFFFFD, HI=0xFFFFFFFF, with done_o exactly 34 edges after the accept edge.
REQ-034 The bench SHALL drive DIV a=0x80000000, b=0xFFFFFFFF and check LO=0x80000000, HI=0; then DIVU a=100, b=0 and check HI/LO unchanged with done_o one cycle after accept.
REQ-035 The bench SHALL assert flush_i 10 cycles into a DIVU and check no done_o, HI/LO preserved and busy_o=0 on the next cycle; it SHALL also start a new request in the done_o cycle and check it is accepted.
REQ-036 The bench SHALL assert rst mid-MULT and check all outputs are 0 immediately; it SHALL also check that MTLO a=0x12345678 gives LO=0x12345678 with HI unchanged.
